bcd_operand_entry: RTL

Push-button operand entry stage that sits directly upstream of the BCD adder. It captures decimal digit presses from the pushbutton bank and shifts them into two multi-digit BCD operand registers, A then B. A small state machine sequences the entry and raises op_valid once both operands are complete. The adder consumes op_a and op_b combinationally; the display logic uses state and digit_count.

---
 rtl/bcd_entry_pkg.sv | 25 ++
 rtl/bcd_operand_entry_pb_edge.sv | 22 ++
 rtl/bcd_operand_entry.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/bcd_entry_pkg.sv
// Shared types and constants for the BCD operand entry slice.
// Holds the entry FSM state type and the digit priority helper.
package bcd_entry_pkg;

  localparam int BCD_W = 4;
  localparam int NKEYS = 10;

  typedef enum logic [1:0] {
    ENTRY_A = 2'd0,
    ENTRY_B = 2'd1,
    DONE    = 2'd2
  } entry_state_t;

  function automatic logic [BCD_W-1:0] low_digit(
    input logic [NKEYS-1:0] ev
  );
    logic [BCD_W-1:0] r;
    r = '0;
    for (int k = NKEYS - 1; k >= 0; k--) begin
      if (ev[k]) r = BCD_W'(k);
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_operand_entry_pb_edge.sv
// Rising-edge detector for a group of pushbuttons (module pb_edge).
// A held key yields one single-cycle rise pulse.
module pb_edge #(
  parameter int W = 1
) (
  input  logic         hz100,
  input  logic         reset,
  input  logic [W-1:0] in,
  output logic [W-1:0] rise
);

  logic [W-1:0] q;

  // previous key levels
  always_ff @(posedge hz100) begin
    if (reset) q <= '0;
    else       q <= in;
  end

  assign rise = in & ~q;

endmodule

// File: rtl/bcd_operand_entry.sv
// Pushbutton entry of two packed-BCD operands ahead of the adder.
// Optional macro BCD_BKSP_EN adds a backspace key.
module bcd_operand_entry
  import bcd_entry_pkg::*;
#(
  parameter int NDIGITS = 2
) (
  input  logic                     hz100,
  input  logic                     reset,
  input  logic [NKEYS-1:0]         digit_pb,
  input  logic                     enter_pb,
  input  logic                     clear_pb,
  input  logic                     bksp_pb,
  output logic [BCD_W*NDIGITS-1:0] op_a,
  output logic [BCD_W*NDIGITS-1:0] op_b,
  output logic                     op_valid,
  output logic [1:0]               state,
  output logic [2:0]               digit_count
);

  localparam int W = BCD_W * NDIGITS;

  logic [NKEYS-1:0] dig_ev;
  logic [1:0]       ctl_ev;
  logic             enter_ev;
  logic             clr_ev;
  logic             bksp_ev;
  logic [BCD_W-1:0] dig;

  logic [1:0]   st_q, st_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         v_q, v_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [W-1:0] cur, cur_d;

  pb_edge #(.W(NKEYS)) u_dig (
    .hz100 (hz100),
    .reset (reset),
    .in    (digit_pb),
    .rise  (dig_ev)
  );

  pb_edge #(.W(2)) u_ctl (
    .hz100 (hz100),
    .reset (reset),
    .in    ({clear_pb, enter_pb}),
    .rise  (ctl_ev)
  );

  assign enter_ev = ctl_ev[0];
  assign clr_ev   = ctl_ev[1];
  assign dig      = low_digit(dig_ev);

`ifdef BCD_BKSP_EN
  pb_edge #(.W(1)) u_bk (
    .hz100 (hz100),
    .reset (reset),
    .in    (bksp_pb),
    .rise  (bksp_ev)
  );
`else
  logic unused_bksp;
  assign unused_bksp = bksp_pb;
  assign bksp_ev     = 1'b0;
`endif

  // state and operand registers
  always_ff @(posedge hz100) begin
    if (reset) begin
      st_q  <= ENTRY_A;
      a_q   <= '0;
      b_q   <= '0;
      v_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      a_q   <= a_d;
      b_q   <= b_d;
      v_q   <= v_d;
      cnt_q <= cnt_d;
    end
  end

  assign cur = (st_q == ENTRY_B) ? b_q : a_q;

  // next state: clear > enter > bksp > digit
  always_comb begin
    st_d  = st_q;
    a_d   = a_q;
    b_d   = b_q;
    v_d   = v_q;
    cnt_d = cnt_q;
    cur_d = cur;
    if (clr_ev) begin
      st_d  = ENTRY_A;
      a_d   = '0;
      b_d   = '0;
      v_d   = 1'b0;
      cnt_d = '0;
    end else begin
      case (st_q)
        ENTRY_A, ENTRY_B: begin
          if (enter_ev) begin
            if (st_q == ENTRY_A) begin
              st_d  = ENTRY_B;
              cnt_d = '0;
            end else begin
              st_d = DONE;
              v_d  = 1'b1;
            end
          end else if (bksp_ev) begin
            if (cnt_q != 3'd0) begin
              cur_d = cur >> BCD_W;
              cnt_d = cnt_q - 3'd1;
            end
          end else if (|dig_ev) begin
            if (cnt_q < 3'(NDIGITS)) begin
              cur_d = W'({cur, dig});
              cnt_d = cnt_q + 3'd1;
            end
          end
          if (st_q == ENTRY_A) a_d = cur_d;
          else                 b_d = cur_d;
        end
        DONE: begin
          if (enter_ev) begin
            st_d  = ENTRY_A;
            a_d   = '0;
            b_d   = '0;
            v_d   = 1'b0;
            cnt_d = '0;
          end
        end
        default: st_d = ENTRY_A;
      endcase
    end
  end

  assign op_a        = a_q;
  assign op_b        = b_q;
  assign op_valid    = v_q;
  assign state       = st_q;
  assign digit_count = cnt_q;

endmodule
